// File: rtl/mvb_split_items_if.sv
// Purpose: MVB bus bundle of ITEMS items, ITEM_WIDTH bits each, with per-item valid.
// Latency: none, wires only.
// Backpressure: a word moves on any cycle where src_rdy and dst_rdy are both high.
// Signals: data (item i at slice i), vld (per-item valid), src_rdy (word present),
//          dst_rdy (sink ready, driven by the receiving side).
interface mvb_split_items_if #(
   parameter int ITEMS      = 2,
   parameter int ITEM_WIDTH = 8
);
   logic [ITEMS*ITEM_WIDTH-1:0] data;
   logic [ITEMS-1:0]            vld;
   logic                        src_rdy;
   logic                        dst_rdy;

   // master = producer of words, slave = consumer of words
   modport master (output data, output vld, output src_rdy, input dst_rdy);
   modport slave  (input data, input vld, input src_rdy, output dst_rdy);
endinterface

// File: rtl/mvb_split_items.sv
// Purpose: splits each RX MVB item into a low part (tx0) and a high part (tx1), each output buffered.
// Latency: 1 cycle from RX accept to word present on both outputs; no bypass path.
// Backpressure: rx.dst_rdy drops when either output FIFO is full; outputs drain independently.
// Ports: clk, reset (async, active high), rx (slave MVB, ITEMS x (TX0+TX1) bits),
//        tx0 (master MVB, ITEMS x TX0_ITEM_WIDTH), tx1 (master MVB, ITEMS x TX1_ITEM_WIDTH).

// Word FIFO used once per output. Occupancy is registered so full/empty
// never depend combinationally on the read request.
module mvb_split_items_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    occ;
   logic             wr_ok;
   logic             rd_ok;

   assign full   = (occ == CW'(DEPTH));
   assign empty  = (occ == '0);
   // A full FIFO refuses the write even when a read frees a slot in the
   // same cycle; the slot becomes usable one cycle later.
   assign wr_ok  = wr_en && !full;
   assign rd_ok  = rd_en && !empty;
   assign rd_dat = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end
endmodule

module mvb_split_items #(
   parameter int ITEMS          = 2,
   parameter int TX0_ITEM_WIDTH = 8,
   parameter int TX1_ITEM_WIDTH = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic               clk,
   input  logic               reset,
   mvb_split_items_if.slave   rx,
   mvb_split_items_if.master  tx0,
   mvb_split_items_if.master  tx1
);
   localparam int RX_W   = TX0_ITEM_WIDTH + TX1_ITEM_WIDTH;
   localparam int F0_W   = ITEMS * TX0_ITEM_WIDTH + ITEMS;
   localparam int F1_W   = ITEMS * TX1_ITEM_WIDTH + ITEMS;

   logic [ITEMS*TX0_ITEM_WIDTH-1:0] lo_data;
   logic [ITEMS*TX1_ITEM_WIDTH-1:0] hi_data;
   logic [F0_W-1:0]                 f0_wr_dat;
   logic [F1_W-1:0]                 f1_wr_dat;
   logic [F0_W-1:0]                 f0_rd_dat;
   logic [F1_W-1:0]                 f1_rd_dat;
   logic                            f0_full;
   logic                            f1_full;
   logic                            f0_empty;
   logic                            f1_empty;
   logic                            accept;
   logic                            wr_en;
   logic                            f0_rd;
   logic                            f1_rd;

   // Split every RX item into its low and high part.
   always_comb begin
      lo_data = '0;
      hi_data = '0;
      for (int i = 0; i < ITEMS; i++) begin
         lo_data[i*TX0_ITEM_WIDTH +: TX0_ITEM_WIDTH] = rx.data[i*RX_W +: TX0_ITEM_WIDTH];
         hi_data[i*TX1_ITEM_WIDTH +: TX1_ITEM_WIDTH] = rx.data[i*RX_W + TX0_ITEM_WIDTH +: TX1_ITEM_WIDTH];
      end
   end

   // Ready comes from registered occupancy only, so there is no path from
   // either tx dst_rdy to rx.dst_rdy.
   assign rx.dst_rdy = !f0_full && !f1_full;
   assign accept     = rx.src_rdy && rx.dst_rdy && !reset;
   // Words with no valid item are consumed and dropped; both FIFOs are always
   // written together, which keeps word k on tx0 paired with word k on tx1.
   assign wr_en      = accept && (rx.vld != '0);

   assign f0_wr_dat  = {rx.vld, lo_data};
   assign f1_wr_dat  = {rx.vld, hi_data};

   assign f0_rd      = !f0_empty && tx0.dst_rdy;
   assign f1_rd      = !f1_empty && tx1.dst_rdy;

   mvb_split_items_fifo #(
      .WIDTH (F0_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo0 (
      .clk    (clk),
      .rst    (reset),
      .wr_en  (wr_en),
      .wr_dat (f0_wr_dat),
      .rd_en  (f0_rd),
      .rd_dat (f0_rd_dat),
      .full   (f0_full),
      .empty  (f0_empty)
   );

   mvb_split_items_fifo #(
      .WIDTH (F1_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo1 (
      .clk    (clk),
      .rst    (reset),
      .wr_en  (wr_en),
      .wr_dat (f1_wr_dat),
      .rd_en  (f1_rd),
      .rd_dat (f1_rd_dat),
      .full   (f1_full),
      .empty  (f1_empty)
   );

   // Head entries drive the outputs directly; they only move on a read, so
   // they stay stable while a consumer stalls.
   assign tx0.src_rdy = !f0_empty;
   assign tx0.data    = f0_rd_dat[ITEMS*TX0_ITEM_WIDTH-1:0];
   assign tx0.vld     = f0_rd_dat[F0_W-1 -: ITEMS];

   assign tx1.src_rdy = !f1_empty;
   assign tx1.data    = f1_rd_dat[ITEMS*TX1_ITEM_WIDTH-1:0];
   assign tx1.vld     = f1_rd_dat[F1_W-1 -: ITEMS];
endmodule
